// File: rtl/fadd_pkg.sv
// Shared types and helpers for the fadd arbiter slice.
package fadd_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned NREQ_MAX = 8;

  typedef logic [FP_W-1:0] fp_word_t;

  function automatic logic [NREQ_MAX-1:0] onehot(input logic [2:0] id);
    logic [NREQ_MAX-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fadd.sv
// Combinational single-precision adder: truncating, flushes underflow to zero,
// saturates to infinity and flags ovf when the exponent overflows.
module fadd
  import fadd_pkg::*;
(
  input  fp_word_t a_i,
  input  fp_word_t b_i,
  output fp_word_t res_o,
  output logic     ovf_o
);

  logic              a_big;
  fp_word_t          big, sml;
  logic [7:0]        e_big, e_sml, e_diff;
  logic [26:0]       m_big, m_sml, m_al;
  logic [27:0]       m_sum;
  logic [22:0]       frac_n;
  logic [4:0]        lz;
  logic              lz_found;
  logic signed [9:0] e_res;

  always_comb begin
    a_big  = a_i[30:0] >= b_i[30:0];
    big    = a_big ? a_i : b_i;
    sml    = a_big ? b_i : a_i;
    e_big  = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    e_sml  = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    // hidden bit at [26], three guard bits below the stored fraction
    m_big  = {big[30:23] != 8'd0, big[22:0], 3'b000};
    m_sml  = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    e_diff = e_big - e_sml;
    m_al   = (e_diff > 8'd26) ? '0 : (m_sml >> e_diff);

    if (big[31] == sml[31]) begin
      m_sum = {1'b0, m_big} + {1'b0, m_al};
    end else begin
      m_sum = {1'b0, m_big} - {1'b0, m_al};
    end

    lz       = '0;
    lz_found = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!lz_found && m_sum[26-i]) begin
        lz       = 5'(i);
        lz_found = 1'b1;
      end
    end
    frac_n = 23'((m_sum[26:0] << lz) >> 3);

    if (m_sum[27]) begin
      e_res = $signed({2'b00, e_big}) + 10'sd1;
    end else begin
      e_res = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
    end

    res_o = '0;
    ovf_o = 1'b0;
    if (m_sum == '0 || e_res < 10'sd1) begin
      res_o = '0;
    end else if (e_res > 10'sd254) begin
      res_o = {big[31], 8'hFF, 23'd0};
      ovf_o = 1'b1;
    end else if (m_sum[27]) begin
      res_o = {big[31], e_res[7:0], m_sum[26:4]};
    end else begin
      res_o = {big[31], e_res[7:0], frac_n};
    end
  end

endmodule

// File: rtl/fadd_arbiter_rr_pick.sv
// Round-robin picker: first requester after ptr_i (wrapping) wins.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            any_o
);

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!any_o && req_i[(32'(ptr_i) + k) % NREQ]) begin
        gnt_o[(32'(ptr_i) + k) % NREQ] = 1'b1;
        gnt_id_o = ID_W'((32'(ptr_i) + k) % NREQ);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one fadd between NREQ requesters through a
// two-stage (operand, result) valid/ready pipeline.
module fadd_arbiter
  import fadd_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output fp_word_t             rsp_res,
  output logic                 rsp_ovf,
  output logic                 busy
);

  localparam int unsigned ID_W = $clog2(NREQ);

  logic            op_valid_q;
  fp_word_t        op_a_q, op_b_q;
  logic [ID_W-1:0] op_id_q;
  logic            res_valid_q;
  fp_word_t        res_q;
  logic            ovf_q;
  logic [ID_W-1:0] res_id_q;
  logic [ID_W-1:0] rr_ptr_q;

  logic            drain, res_en, op_en, accept;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  fp_word_t        sel_a, sel_b;
  fp_word_t        fadd_res;
  logic            fadd_ovf;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (grant),
    .gnt_id_o (gnt_id),
    .any_o    (gnt_any)
  );

  fadd u_fadd (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .res_o (fadd_res),
    .ovf_o (fadd_ovf)
  );

  // Ready chains backwards: a drained result frees RES, which frees OP in the same cycle.
  assign drain     = res_valid_q & rsp_ready[res_id_q];
  assign res_en    = ~res_valid_q | drain;
  assign op_en     = ~op_valid_q | res_en;
  assign req_ready = grant & {NREQ{op_en}};
  assign accept    = gnt_any & op_en;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[FP_W*i +: FP_W];
        sel_b = req_b[FP_W*i +: FP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      res_id_q    <= '0;
      rr_ptr_q    <= ID_W'(NREQ - 1);
    end else begin
      if (op_en) begin
        op_valid_q <= accept;
        if (accept) begin
          op_a_q   <= sel_a;
          op_b_q   <= sel_b;
          op_id_q  <= gnt_id;
          rr_ptr_q <= gnt_id;
        end
      end
      if (res_en) begin
        res_valid_q <= op_valid_q;
        if (op_valid_q) begin
          res_q    <= fadd_res;
          ovf_q    <= fadd_ovf;
          res_id_q <= op_id_q;
        end
      end
    end
  end

  assign rsp_valid = res_valid_q ? NREQ'(onehot(3'(res_id_q))) : '0;
  assign rsp_res   = res_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = op_valid_q | res_valid_q;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter with four requesters.
module tb_fadd_arbiter;

  localparam int unsigned NREQ = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_res;
  logic         rsp_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  fadd_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 4'hF;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected %b", rsp_valid, 4'b0000); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_res !== 32'h0) begin errors++; $display("FAIL reset_rsp_res: got %h expected 00000000", rsp_res); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovf: got %b expected 0", rsp_ovf); end
    tick; tick;
    rst_n = 1'b1;
    // fill both stages while responses are blocked
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h3F800000;
    req_a[63:32] = 32'h40000000; req_b[63:32] = 32'h40000000;
    req_valid = 4'b0001; tick;
    req_valid = 4'b0010; tick;
    req_valid = 4'b0000; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_full_busy: got %b expected 1", busy); end
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL reset_full_rsp: got %b expected %b", rsp_valid, 4'b0001); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_async_rsp_valid: got %b expected %b", rsp_valid, 4'b0000); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_async_req_ready: got %b expected %b", req_ready, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b expected 0", busy); end
    tick;
    rst_n = 1'b1; rsp_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_no_stale_rsp: got %b expected %b", rsp_valid, 4'b0000); end
      tick;
    end
    req_valid = 4'b0011; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected %b", req_ready, 4'b0001); end
    tick;
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_second_grant: got %b expected %b", req_ready, 4'b0010); end
    tick;
    req_valid = 4'b0000; #1;
    checks++; if (rsp_valid !== 4'b0001 || rsp_res !== 32'h40000000) begin errors++; $display("FAIL reset_rsp0: got %b/%h expected 0001/40000000", rsp_valid, rsp_res); end
    tick;
    checks++; if (rsp_valid !== 4'b0010 || rsp_res !== 32'h40800000) begin errors++; $display("FAIL reset_rsp1: got %b/%h expected 0010/40800000", rsp_valid, rsp_res); end
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    rsp_ready = 4'hF;
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000;
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0001); end
    tick;
    req_valid = 4'b0000; #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp: got %b expected %b", rsp_valid, 4'b0000); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick;
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b expected %b", rsp_valid, 4'b0001); end
    checks++; if (rsp_res !== 32'h40400000) begin errors++; $display("FAIL single_rsp_res: got %h expected 40400000", rsp_res); end
    checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL single_rsp_ovf: got %b expected 0", rsp_ovf); end
    tick;
    checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_drained: got %b/%b expected 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_res [4];
    logic [3:0]  exp_oh;
    exp_res = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    do_reset;
    req_a[31:0]   = 32'h3F800000; req_b[31:0]   = 32'h3F800000;
    req_a[63:32]  = 32'h3F800000; req_b[63:32]  = 32'h40000000;
    req_a[95:64]  = 32'h40000000; req_b[95:64]  = 32'h40000000;
    req_a[127:96] = 32'h40000000; req_b[127:96] = 32'h40400000;
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = 4'h0;
      #1;
      if (k < 8) begin
        exp_oh = 4'(1 << (k % 4));
        checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_oh); end
      end
      if (k >= 2) begin
        exp_oh = 4'(1 << ((k - 2) % 4));
        checks++; if (rsp_valid !== exp_oh || rsp_res !== exp_res[(k-2)%4]) begin errors++; $display("FAIL rr_rsp[%0d]: got %b/%h expected %b/%h", k, rsp_valid, rsp_res, exp_oh, exp_res[(k-2)%4]); end
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    rsp_ready = 4'h0;
    req_valid = 4'hF; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0: got %b expected %b", req_ready, 4'b0001); end
    tick; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b expected %b", req_ready, 4'b0010); end
    tick;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected %b", s, req_ready, 4'b0000); end
      checks++; if (rsp_valid !== 4'b0001 || rsp_res !== 32'h40000000) begin errors++; $display("FAIL bp_stall_rsp[%0d]: got %b/%h expected 0001/40000000", s, rsp_valid, rsp_res); end
      tick;
    end
    rsp_ready = 4'hF; #1;
    checks++; if (rsp_valid !== 4'b0001 || req_ready !== 4'b0100) begin errors++; $display("FAIL bp_resume0: got %b/%b expected 0001/0100", rsp_valid, req_ready); end
    tick;
    checks++; if (rsp_valid !== 4'b0010 || rsp_res !== 32'h40400000 || req_ready !== 4'b1000) begin errors++; $display("FAIL bp_resume1: got %b/%h/%b expected 0010/40400000/1000", rsp_valid, rsp_res, req_ready); end
    tick;
    checks++; if (rsp_valid !== 4'b0100 || rsp_res !== 32'h40800000 || req_ready !== 4'b0001) begin errors++; $display("FAIL bp_resume2: got %b/%h/%b expected 0100/40800000/0001", rsp_valid, rsp_res, req_ready); end
    tick;
  endtask

  task automatic test_sparse;
    logic [3:0] vld [7];
    logic [3:0] rdy [7];
    vld = '{4'b0010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 4'b1010};
    rdy = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0010};
    do_reset;
    for (int s = 0; s < 7; s++) begin
      req_valid = vld[s]; #1;
      checks++; if (req_ready !== rdy[s]) begin errors++; $display("FAIL sparse_grant[%0d]: got %b expected %b", s, req_ready, rdy[s]); end
      tick;
    end
    req_valid = 4'h0;
    tick; tick;
  endtask

  task automatic test_route_hold;
    do_reset;
    rsp_ready = 4'b1011;
    req_a[95:64] = 32'h3FC00000; req_b[95:64] = 32'h3FC00000;
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL route_ready: got %b expected %b", req_ready, 4'b0100); end
    tick;
    req_valid = 4'b0000;
    tick;
    for (int s = 0; s < 3; s++) begin
      checks++; if (rsp_valid !== 4'b0100 || rsp_res !== 32'h40400000) begin errors++; $display("FAIL route_hold[%0d]: got %b/%h expected 0100/40400000", s, rsp_valid, rsp_res); end
      tick;
    end
    rsp_ready = 4'b0100; #1;
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL route_before_drain: got %b expected %b", rsp_valid, 4'b0100); end
    tick;
    checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL route_drained: got %b/%b expected 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_overflow;
    int          ids  [3];
    logic [31:0] va   [3];
    logic [31:0] vb   [3];
    logic [31:0] vr   [3];
    logic        vo   [3];
    logic [3:0]  oh;
    ids = '{3, 0, 1};
    va  = '{32'h7F000000, 32'h3F800000, 32'h40400000};
    vb  = '{32'h7F000000, 32'hBF800000, 32'hBF800000};
    vr  = '{32'h7F800000, 32'h00000000, 32'h40000000};
    vo  = '{1'b1, 1'b0, 1'b0};
    do_reset;
    for (int s = 0; s < 3; s++) begin
      oh = 4'(1 << ids[s]);
      req_a[32*ids[s] +: 32] = va[s];
      req_b[32*ids[s] +: 32] = vb[s];
      req_valid = oh; #1;
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL ovf_ready[%0d]: got %b expected %b", s, req_ready, oh); end
      tick;
      req_valid = 4'h0;
      tick;
      checks++; if (rsp_valid !== oh || rsp_res !== vr[s] || rsp_ovf !== vo[s]) begin errors++; $display("FAIL ovf_rsp[%0d]: got %b/%h/%b expected %b/%h/%b", s, rsp_valid, rsp_res, rsp_ovf, oh, vr[s], vo[s]); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_sparse;
    test_route_hold;
    test_overflow;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
